req_buffer_bridge: RTL and testbench

// - Elastic request buffer on the bridge request path. Sits directly downstream of the

---
 rtl/bridge_req_pkg.sv | 51 +++++
 rtl/req_buffer_bridge_if.sv | 27 ++
 rtl/bridge_fifo_core.sv | 73 +++++++
 rtl/req_buffer_bridge.sv | 64 ++++++
 tb/tb_req_buffer_bridge.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_req_pkg.sv
// Shared request-path definitions for the request buffer bridge.
// - Field widths, flat-vector offsets and a packed request struct.
// - pack_req()/unpack_req() convert between the struct and the flat storage word.
//   Flat order, MSB to LSB: {aux, id, be, wen, add, wtag, wdata}.
package bridge_req_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned ID_WIDTH   = 16;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned AUX_WIDTH  = 32;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned TAG_WIDTH  = DATA_WIDTH / 8;

  localparam int unsigned WDATA_OFF = 0;
  localparam int unsigned WTAG_OFF  = WDATA_OFF + DATA_WIDTH;
  localparam int unsigned ADD_OFF   = WTAG_OFF + TAG_WIDTH;
  localparam int unsigned WEN_OFF   = ADD_OFF + ADDR_WIDTH;
  localparam int unsigned BE_OFF    = WEN_OFF + 1;
  localparam int unsigned ID_OFF    = BE_OFF + BE_WIDTH;
  localparam int unsigned AUX_OFF   = ID_OFF + ID_WIDTH;
  localparam int unsigned REQ_WIDTH = AUX_OFF + AUX_WIDTH;

  typedef struct packed {
    logic [AUX_WIDTH-1:0]  aux;
    logic [ID_WIDTH-1:0]   id;
    logic [BE_WIDTH-1:0]   be;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] add;
    logic [TAG_WIDTH-1:0]  wtag;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef logic [REQ_WIDTH-1:0] req_vec_t;

  function automatic req_vec_t pack_req(req_t r);
    return {r.aux, r.id, r.be, r.wen, r.add, r.wtag, r.wdata};
  endfunction

  function automatic req_t unpack_req(req_vec_t v);
    req_t r;
    r.wdata = v[WDATA_OFF +: DATA_WIDTH];
    r.wtag  = v[WTAG_OFF +: TAG_WIDTH];
    r.add   = v[ADD_OFF +: ADDR_WIDTH];
    r.wen   = v[WEN_OFF];
    r.be    = v[BE_OFF +: BE_WIDTH];
    r.id    = v[ID_OFF +: ID_WIDTH];
    r.aux   = v[AUX_OFF +: AUX_WIDTH];
    return r;
  endfunction

endpackage

// File: rtl/req_buffer_bridge_if.sv
// Request channel bundle: req/gnt handshake plus the seven request fields.
// - master: drives data_req and fields, receives data_gnt.
// - slave:  receives data_req and fields, drives data_gnt.
interface req_buffer_bridge_if;
  import bridge_req_pkg::*;

  logic                  data_req;
  logic                  data_gnt;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic [TAG_WIDTH-1:0]  data_wtag;
  logic [ADDR_WIDTH-1:0] data_add;
  logic                  data_wen;
  logic [BE_WIDTH-1:0]   data_be;
  logic [ID_WIDTH-1:0]   data_id;
  logic [AUX_WIDTH-1:0]  data_aux;

  modport master (
    output data_req, data_wdata, data_wtag, data_add, data_wen, data_be, data_id, data_aux,
    input  data_gnt
  );

  modport slave (
    input  data_req, data_wdata, data_wtag, data_add, data_wen, data_be, data_id, data_aux,
    output data_gnt
  );

endinterface

// File: rtl/bridge_fifo_core.sv
// Generic synchronous-reset FIFO storage with occupancy count.
// Ports: clk_i, rst_ni (sync, active-low), push_i/wdata_i, pop_i/rdata_o (head entry),
//        full_o, empty_o, count_o.
// Push while full and pop while empty are ignored. DEPTH must be a power of two >= 2 so the
// pointers wrap naturally.
module bridge_fifo_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic            pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/req_buffer_bridge.sv
// Elastic request buffer between the arbitration tree root and the target port.
// Ports: clk, rst_n (sync, active-low), up_io (slave side, from the tree),
//        dn_io (master side, to the target), count_o (occupancy).
// Grant upstream depends only on buffer state, which cuts the combinational req->gnt path.
// Head fields are driven straight from storage; there is no fall-through or bypass.
module req_buffer_bridge
  import bridge_req_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  req_buffer_bridge_if.slave     up_io,
  req_buffer_bridge_if.master    dn_io,
  output logic [CNT_WIDTH-1:0]   count_o
);

  req_t     wr_req, rd_req;
  req_vec_t rd_vec;
  logic     full, empty, push, pop;

  always_comb begin
    wr_req       = '0;
    wr_req.wdata = up_io.data_wdata;
    wr_req.wtag  = up_io.data_wtag;
    wr_req.add   = up_io.data_add;
    wr_req.wen   = up_io.data_wen;
    wr_req.be    = up_io.data_be;
    wr_req.id    = up_io.data_id;
    wr_req.aux   = up_io.data_aux;
  end

  // Both handshakes are masked by rst_n so nothing is granted or offered on a reset cycle.
  assign up_io.data_gnt = ~full & rst_n;
  assign push           = up_io.data_req & up_io.data_gnt;
  assign dn_io.data_req = ~empty & rst_n;
  assign pop            = dn_io.data_req & dn_io.data_gnt;

  bridge_fifo_core #(
    .WIDTH (REQ_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (pack_req(wr_req)),
    .pop_i   (pop),
    .rdata_o (rd_vec),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  assign rd_req           = unpack_req(rd_vec);
  assign dn_io.data_wdata = rd_req.wdata;
  assign dn_io.data_wtag  = rd_req.wtag;
  assign dn_io.data_add   = rd_req.add;
  assign dn_io.data_wen   = rd_req.wen;
  assign dn_io.data_be    = rd_req.be;
  assign dn_io.data_id    = rd_req.id;
  assign dn_io.data_aux   = rd_req.aux;

endmodule

// File: tb/tb_req_buffer_bridge.sv
// Self-checking bench for req_buffer_bridge against a queue-based FIFO reference model.
module tb_req_buffer_bridge;
  import bridge_req_pkg::*;

  localparam int unsigned DEPTH     = 2;
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [CNT_WIDTH-1:0] count_o;

  req_buffer_bridge_if up_if ();
  req_buffer_bridge_if dn_if ();

  req_buffer_bridge #(
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .up_io   (up_if),
    .dn_io   (dn_if),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  req_t        mq[$];        // reference model contents, head at index 0
  int unsigned out_ids[$];   // IDs observed leaving the DUT
  int unsigned pops_seen = 0;
  req_t        cur;
  logic        cleared = 1'b0;
  logic        gnt_smp;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic req_vec_t dn_vec();
    req_t o;
    o.wdata = dn_if.data_wdata;
    o.wtag  = dn_if.data_wtag;
    o.add   = dn_if.data_add;
    o.wen   = dn_if.data_wen;
    o.be    = dn_if.data_be;
    o.id    = dn_if.data_id;
    o.aux   = dn_if.data_aux;
    return pack_req(o);
  endfunction

  function automatic req_t mk(input logic [ID_WIDTH-1:0] id);
    req_t r;
    r.wdata = $urandom;
    r.wtag  = TAG_WIDTH'($urandom);
    r.add   = $urandom;
    r.wen   = 1'($urandom);
    r.be    = BE_WIDTH'($urandom);
    r.id    = id;
    r.aux   = $urandom;
    return r;
  endfunction

  task automatic set_up(input logic v, input req_t r);
    cur              = r;
    up_if.data_req   = v;
    up_if.data_wdata = r.wdata;
    up_if.data_wtag  = r.wtag;
    up_if.data_add   = r.add;
    up_if.data_wen   = r.wen;
    up_if.data_be    = r.be;
    up_if.data_id    = r.id;
    up_if.data_aux   = r.aux;
  endtask

  // One clock: check outputs at the negedge against the model, then advance the model.
  task automatic tick(output logic pushed);
    logic do_push, do_pop;
    @(negedge clk);
    gnt_smp = up_if.data_gnt;
    if (!rst_n) begin
      check_val("rst_gnt", up_if.data_gnt, 0);
      check_val("rst_req", dn_if.data_req, 0);
      if (cleared) begin
        check_val("rst_count", count_o, 0);
        check_val("rst_fields", dn_vec(), 0);
      end
    end else begin
      check_val("gnt", up_if.data_gnt, mq.size() < DEPTH);
      check_val("req", dn_if.data_req, mq.size() > 0);
      check_val("count", count_o, mq.size());
      if (mq.size() > 0) check_val("head", dn_vec(), pack_req(mq[0]));
    end
    if (dn_if.data_req && dn_if.data_gnt) begin
      pops_seen++;
      out_ids.push_back(int'(dn_if.data_id));
    end
    do_push = rst_n && up_if.data_req && (mq.size() < DEPTH);
    do_pop  = rst_n && (mq.size() > 0) && dn_if.data_gnt;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      cleared = 1'b1;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(cur);
        cleared = 1'b0;
      end
    end
    pushed = do_push;
    #1;
  endtask

  task automatic push_one(input req_t r);
    logic p;
    int   n;
    set_up(1'b1, r);
    p = 1'b0;
    n = 0;
    while (!p && n < 20) begin
      tick(p);
      n++;
    end
    if (!p) check_val("push_timeout", 0, 1);
    set_up(1'b0, r);
  endtask

  task automatic drain();
    logic p;
    int   n;
    dn_if.data_gnt = 1'b1;
    set_up(1'b0, cur);
    n = 0;
    while (mq.size() > 0 && n < 20) begin
      tick(p);
      n++;
    end
    check_val("drain_done", mq.size(), 0);
  endtask

  initial begin
    logic        p;
    int          start, drops, pushed_n, cyc;
    req_t        r;
    logic [15:0] bp_exp [3];

    // Reset with a request held upstream.
    dn_if.data_gnt = 1'b0;
    set_up(1'b1, mk(16'h0F0F));
    rst_n = 1'b0;
    repeat (3) tick(p);
    rst_n = 1'b1;
    tick(p);
    check_val("first_push_count", count_o, 1);
    drain();

    // Single write with grant held high.
    r.add = 32'h1000_0004; r.wdata = 32'hDEAD_BEEF; r.wen = 1'b0; r.be = 4'hF;
    r.id = 16'h0002; r.wtag = 4'h5; r.aux = 32'h0000_00A5;
    dn_if.data_gnt = 1'b1;
    set_up(1'b1, r);
    tick(p);
    set_up(1'b0, r);
    check_val("single_req", dn_if.data_req, 1);
    check_val("single_fields", dn_vec(), pack_req(r));
    tick(p);
    check_val("single_count", count_o, 0);

    // Back-pressure: third request must be held off until the target grants.
    dn_if.data_gnt = 1'b0;
    start = out_ids.size();
    push_one(mk(16'd1));
    push_one(mk(16'd2));
    set_up(1'b1, mk(16'd3));
    tick(p);
    tick(p);
    check_val("bp_gnt_low", up_if.data_gnt, 0);
    check_val("bp_count", count_o, 2);
    dn_if.data_gnt = 1'b1;
    begin
      int n = 0;
      p = 1'b0;
      while (!p && n < 10) begin
        tick(p);
        n++;
      end
      if (!p) check_val("bp_push3_timeout", 0, 1);
    end
    drain();
    bp_exp[0] = 16'd1; bp_exp[1] = 16'd2; bp_exp[2] = 16'd3;
    check_val("bp_out_n", out_ids.size() - start, 3);
    for (int i = 0; i < 3; i++) begin
      if (start + i < out_ids.size()) check_val("bp_order", out_ids[start+i], bp_exp[i]);
    end

    // Streaming: 100 back-to-back requests.
    start = out_ids.size();
    drops = 0;
    pops_seen = 0;
    dn_if.data_gnt = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_up(1'b1, mk(16'(i + 100)));
      tick(p);
      if (!gnt_smp) drops++;
    end
    set_up(1'b0, cur);
    tick(p);
    check_val("stream_pops", pops_seen, 100);
    check_val("stream_gnt_drops", drops, 0);
    for (int i = 0; i < 100; i++) begin
      if (start + i < out_ids.size()) check_val("stream_order", out_ids[start+i], i + 100);
    end
    drain();

    // Random traffic with upstream holding requests until granted.
    pushed_n = 0;
    cyc = 0;
    p = 1'b0;
    set_up(1'b0, cur);
    while (pushed_n < 10000 && cyc < 60000) begin
      if (!up_if.data_req || p) set_up(1'($urandom % 2), mk(16'($urandom)));
      dn_if.data_gnt = ($urandom % 10) < 3;
      tick(p);
      if (p) pushed_n++;
      cyc++;
    end
    check_val("rand_pushed", pushed_n, 10000);
    drain();

    // Reset mid-stream with the buffer full.
    dn_if.data_gnt = 1'b0;
    push_one(mk(16'h00A1));
    push_one(mk(16'h00A2));
    tick(p);
    check_val("mid_count_full", count_o, 2);
    start = out_ids.size();
    rst_n = 1'b0;
    tick(p);
    rst_n = 1'b1;
    check_val("mid_count_rst", count_o, 0);
    check_val("mid_req_rst", dn_if.data_req, 0);
    dn_if.data_gnt = 1'b1;
    set_up(1'b1, mk(16'h00B1));
    tick(p);
    set_up(1'b0, cur);
    repeat (3) tick(p);
    check_val("mid_out_n", out_ids.size() - start, 1);
    if (out_ids.size() > start) check_val("mid_first_id", out_ids[start], 16'h00B1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
